uart_cmd_controller: RTL and testbench
======================================

Name: uart_cmd_controller

Overview:
Parametrised UART frame command engine; successor to the fixed 18-byte hard-coded decoder in the ECP5 coprocessor top.
Consumes complete RX frames from uart_top and validates them with a selectable check. Dispatches commands to a register file and a coprocessor start/done handshake (e.g. aes_cipher_top), with a timeout. Builds response frames for the UART TX path and counts errors.

Parameters:
FRAME_BYTES, 18, total frame length in bytes; payload = FRAME_BYTES-2 bytes (PW = 8*(FRAME_BYTES-2) bits).
NUM_REGS, 4, payload-wide registers; minimum 2; reg0 drives cop_key, reg1 drives cop_text.
CHECK_MODE, 0, 0: trailer must equal header; 1: trailer must equal XOR of header and all payload bytes.
TIMEOUT_CYCLES, 1024, coprocessor wait limit in clk cycles (>=2).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
rx_valid  in  1  complete frame present on rx_frame
rx_frame  in  8*FRAME_BYTES  byte0 = [7:0] = header/command; byte FRAME_BYTES-1 = trailer
rx_ready  out  1  frame accepted when rx_valid & rx_ready
tx_frame  out  8*FRAME_BYTES  response frame, same layout; stable from tx_send until next accept
tx_send  out  1  one-cycle pulse, triggers uart_top transmit
tx_busy  in  1  UART TX occupied; tx_send is never issued while high
cop_key  out  PW  reg0
cop_text  out  PW  reg1
cop_ld  out  1  one-cycle coprocessor start pulse
cop_done  in  1  coprocessor result valid
cop_result  in  PW  coprocessor output
err_count  out  8  saturating count of rejected frames
state_o  out  2  current FSM state, for LEDs/debug

Behaviour:
- Reset (async, rst low): all outputs 0, registers 0, result reg 0, err_count 0, state IDLE. Any transfer in flight is abandoned; no tx_send or cop_ld is emitted after release until a new frame arrives.
- FSM states: IDLE=0, DECODE=1, RUN=2, RESP=3.
- IDLE: rx_ready=1. On accept, latch rx_frame and go to DECODE. rx_ready=0 in every other state.
- DECODE (1 cycle): apply the check. A failed check or unknown command increments err_count (saturates at 255) and queues NAK 'N', then goes to RESP.
- Commands (header byte), on a passing check:
  - 'A' (0x41): echo; queue 'A' with the same payload, go to RESP.
  - '0'+k, for k < NUM_REGS: write reg[k] <= payload; no response, go to IDLE.
  - 'a'+k, for k < NUM_REGS: queue 'a'+k with payload reg[k], go to RESP.
  - 'E' (0x45): pulse cop_ld in the cycle DECODE is exited, clear the timeout counter, go to RUN.
  - 'B' (0x42): queue 'B' with payload = result reg, go to RESP.
  - '0'+k or 'a'+k with k >= NUM_REGS counts as unknown.
- RUN:
  - cop_done=1: result reg <= cop_result, queue 'E' with cop_result, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without done: queue 'T' with zero payload, increment err_count, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP: wait while tx_busy=1. In the first cycle with tx_busy=0, tx_send=1 for exactly one cycle, then go to IDLE.
- Response framing: byte0 = response command, bytes 1..FRAME_BYTES-2 = payload, trailer computed per CHECK_MODE. NAK payload byte1 = offending header, all other payload bytes 0.
- cop_done outside RUN is ignored (result reg unchanged).
- rx_valid held high across several frames: exactly one frame is accepted per IDLE visit.
- Latency: echo/read/NAK produce tx_send 2 cycles after accept when tx_busy=0. cop_ld is asserted 1 cycle after accept.

Test Plan:
- Reset with rst=0 while in RUN, release -> all outputs 0, state_o=0, rx_ready=1, no cop_ld/tx_send until next frame.
- Echo: frame "A"+"123456789012345A"+"A", tx_busy=0 -> tx_send 2 cycles after accept; tx_frame bytes 0, 1..16, 17 = "A", payload, "A"; err_count=0.
- Write/read: frame '0' with payload 0x000102...0F, then 'a' frame -> cop_key = 0x0F0E...00 (byte1 in LSBs); 'a' response payload identical.
- Bad trailer: header 'A', trailer 'Z' -> 'N' response with byte1=0x41, err_count=1. Repeat 300 times -> err_count=255.
- Encrypt: 'E' frame -> one cop_ld pulse; cop_done with 0x3925841d02dc09fbdc118597196a0b32 five cycles later -> 'E' response carrying that value. A following 'B' returns the same value.
- Timeout, TIMEOUT_CYCLES=16: 'E' with no cop_done -> 'T' response after 16 RUN cycles, err_count+1. Hold tx_busy=1 for 10 cycles -> tx_send delayed until tx_busy falls.
- CHECK_MODE=1: trailer = XOR of header and payload -> accepted; flip one payload bit -> 'N'.

Source files
------------

// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller
// Frame-level command engine between uart_top and a start/done coprocessor.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   rx_valid/ready  incoming frame handshake; rx_frame holds the whole frame
//   tx_frame        response frame, held from tx_send until the next accept
//   tx_send         one-cycle transmit pulse, never issued while tx_busy=1
//   tx_busy         UART transmitter occupied
//   cop_key/text    register 0 / register 1 contents
//   cop_ld          one-cycle coprocessor start pulse
//   cop_done        coprocessor result valid; cop_result is its output
//   err_count       saturating count of rejected frames and timeouts
//   state_o         current FSM state (IDLE=0, DECODE=1, RUN=2, RESP=3)
//
// Frame layout: byte0 = bits [7:0] = command, bytes 1..FRAME_BYTES-2 = payload
// (byte1 in the payload LSBs), byte FRAME_BYTES-1 = trailer.
//
// Handshake: a frame transfers on a rising edge where rx_valid & rx_ready are
// both high. rx_ready is high only in IDLE, so exactly one frame is taken per
// IDLE visit even if rx_valid stays high; rx_frame is only sampled on that edge.
module uart_cmd_controller #(
  parameter int FRAME_BYTES    = 18,
  parameter int NUM_REGS       = 4,
  parameter int CHECK_MODE     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid,
  input  logic [8*FRAME_BYTES-1:0]     rx_frame,
  output logic                         rx_ready,
  output logic [8*FRAME_BYTES-1:0]     tx_frame,
  output logic                         tx_send,
  input  logic                         tx_busy,
  output logic [8*(FRAME_BYTES-2)-1:0] cop_key,
  output logic [8*(FRAME_BYTES-2)-1:0] cop_text,
  output logic                         cop_ld,
  input  logic                         cop_done,
  input  logic [8*(FRAME_BYTES-2)-1:0] cop_result,
  output logic [7:0]                   err_count,
  output logic [1:0]                   state_o
);

  localparam int PW = 8*(FRAME_BYTES-2);
  localparam int FW = 8*FRAME_BYTES;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES-1);

  localparam logic [7:0] CMD_ECHO  = 8'h41; // 'A'
  localparam logic [7:0] CMD_RES   = 8'h42; // 'B'
  localparam logic [7:0] CMD_ENC   = 8'h45; // 'E'
  localparam logic [7:0] CMD_NAK   = 8'h4E; // 'N'
  localparam logic [7:0] CMD_TOUT  = 8'h54; // 'T'
  localparam logic [7:0] CMD_WR0   = 8'h30; // '0'
  localparam logic [7:0] CMD_RD0   = 8'h61; // 'a'

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RUN    = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [FW-1:0]       frm_q;
  logic [PW-1:0]       regs_q [NUM_REGS];
  logic [PW-1:0]       res_q;
  logic [CW-1:0]       cnt_q;

  // Control strobes from the FSM to the datapath.
  logic                frm_ld;
  logic                resp_ld;
  logic [7:0]          resp_cmd;
  logic [PW-1:0]       resp_pl;
  logic                err_inc;
  logic [NUM_REGS-1:0] reg_we;
  logic                res_we;
  logic                cnt_clr;
  logic                cnt_inc;

  logic [7:0]          frm_hdr;
  logic [7:0]          frm_trl;
  logic [PW-1:0]       frm_pl;
  logic                chk_ok;
  logic [NUM_REGS-1:0] wr_sel;
  logic                rd_hit;
  logic [PW-1:0]       rd_val;

  // XOR of a command byte and every payload byte.
  function automatic logic [7:0] byte_xor(input logic [7:0] cmd, input logic [PW-1:0] pl);
    logic [7:0] x;
    x = cmd;
    for (int i = 0; i < FRAME_BYTES-2; i++) begin
      x = x ^ pl[8*i +: 8];
    end
    return x;
  endfunction

  // Trailer that a well-formed frame with this command and payload carries.
  function automatic logic [7:0] trailer_for(input logic [7:0] cmd, input logic [PW-1:0] pl);
    return (CHECK_MODE == 0) ? cmd : byte_xor(cmd, pl);
  endfunction

  assign frm_hdr = frm_q[7:0];
  assign frm_pl  = frm_q[FW-9:8];
  assign frm_trl = frm_q[FW-1 -: 8];
  assign chk_ok  = (frm_trl == trailer_for(frm_hdr, frm_pl));

  // Register-file command decode. Out-of-range indices never match, so they
  // fall through to the unknown-command NAK.
  always_comb begin
    wr_sel = '0;
    rd_hit = 1'b0;
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (frm_hdr == 8'(CMD_WR0 + k)) begin
        wr_sel[k] = 1'b1;
      end
      if (frm_hdr == 8'(CMD_RD0 + k)) begin
        rd_hit = 1'b1;
        rd_val = regs_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    cop_ld   = 1'b0;
    tx_send  = 1'b0;
    frm_ld   = 1'b0;
    resp_ld  = 1'b0;
    resp_cmd = 8'h00;
    resp_pl  = '0;
    err_inc  = 1'b0;
    reg_we   = '0;
    res_we   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          frm_ld  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = RESP;
        if (!chk_ok) begin
          resp_ld  = 1'b1;
          resp_cmd = CMD_NAK;
          resp_pl  = PW'(frm_hdr);
          err_inc  = 1'b1;
        end else if (frm_hdr == CMD_ECHO) begin
          resp_ld  = 1'b1;
          resp_cmd = CMD_ECHO;
          resp_pl  = frm_pl;
        end else if (frm_hdr == CMD_RES) begin
          resp_ld  = 1'b1;
          resp_cmd = CMD_RES;
          resp_pl  = res_q;
        end else if (frm_hdr == CMD_ENC) begin
          // Start pulse is seen by the coprocessor on the edge leaving DECODE.
          cop_ld  = 1'b1;
          cnt_clr = 1'b1;
          state_d = RUN;
        end else if (|wr_sel) begin
          reg_we  = wr_sel;
          state_d = IDLE;
        end else if (rd_hit) begin
          resp_ld  = 1'b1;
          resp_cmd = frm_hdr;
          resp_pl  = rd_val;
        end else begin
          resp_ld  = 1'b1;
          resp_cmd = CMD_NAK;
          resp_pl  = PW'(frm_hdr);
          err_inc  = 1'b1;
        end
      end
      RUN: begin
        // A done arriving in the last counted cycle still wins over timeout.
        if (cop_done) begin
          res_we   = 1'b1;
          resp_ld  = 1'b1;
          resp_cmd = CMD_ENC;
          resp_pl  = cop_result;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_ld  = 1'b1;
          resp_cmd = CMD_TOUT;
          err_inc  = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        if (!tx_busy) begin
          tx_send = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_q     <= '0;
      tx_frame  <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      err_count <= 8'h00;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      if (frm_ld) begin
        frm_q <= rx_frame;
      end
      if (resp_ld) begin
        tx_frame <= {trailer_for(resp_cmd, resp_pl), resp_pl, resp_cmd};
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (reg_we[k]) begin
          regs_q[k] <= frm_pl;
        end
      end
      if (res_we) begin
        res_q <= cop_result;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign cop_key  = regs_q[0];
  assign cop_text = regs_q[1];
  assign state_o  = state_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Bench for uart_cmd_controller: instance 0 uses CHECK_MODE=0, instance 1
// uses CHECK_MODE=1; both FRAME_BYTES=18, NUM_REGS=4, TIMEOUT_CYCLES=16.
module tb_uart_cmd_controller;

  localparam int PW = 128;
  localparam int FW = 144;
  localparam int TO = 16;

  localparam logic [7:0] C_A = 8'h41;
  localparam logic [7:0] C_B = 8'h42;
  localparam logic [7:0] C_E = 8'h45;
  localparam logic [7:0] C_N = 8'h4E;
  localparam logic [7:0] C_T = 8'h54;

  logic          clk;
  logic          rst;
  logic          rx_valid_a   [2];
  logic [FW-1:0] rx_frame_a   [2];
  logic          rx_ready_a   [2];
  logic [FW-1:0] tx_frame_a   [2];
  logic          tx_send_a    [2];
  logic          tx_busy_a    [2];
  logic [PW-1:0] cop_key_a    [2];
  logic [PW-1:0] cop_text_a   [2];
  logic          cop_ld_a     [2];
  logic          cop_done_a   [2];
  logic [PW-1:0] cop_result_a [2];
  logic [7:0]    err_count_a  [2];
  logic [1:0]    state_o_a    [2];

  uart_cmd_controller #(.FRAME_BYTES(18), .NUM_REGS(4), .CHECK_MODE(0), .TIMEOUT_CYCLES(TO)) u_dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_a[0]), .rx_frame(rx_frame_a[0]),
    .rx_ready(rx_ready_a[0]), .tx_frame(tx_frame_a[0]), .tx_send(tx_send_a[0]),
    .tx_busy(tx_busy_a[0]), .cop_key(cop_key_a[0]), .cop_text(cop_text_a[0]),
    .cop_ld(cop_ld_a[0]), .cop_done(cop_done_a[0]), .cop_result(cop_result_a[0]),
    .err_count(err_count_a[0]), .state_o(state_o_a[0])
  );

  uart_cmd_controller #(.FRAME_BYTES(18), .NUM_REGS(4), .CHECK_MODE(1), .TIMEOUT_CYCLES(TO)) u_dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_a[1]), .rx_frame(rx_frame_a[1]),
    .rx_ready(rx_ready_a[1]), .tx_frame(tx_frame_a[1]), .tx_send(tx_send_a[1]),
    .tx_busy(tx_busy_a[1]), .cop_key(cop_key_a[1]), .cop_text(cop_text_a[1]),
    .cop_ld(cop_ld_a[1]), .cop_done(cop_done_a[1]), .cop_result(cop_result_a[1]),
    .err_count(err_count_a[1]), .state_o(state_o_a[1])
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int            n_chk = 0;
  int            n_err = 0;
  logic [FW-1:0] exp_q [$];

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Frame builder from byte-level rules: trailer is the command (mode 0) or
  // the XOR of command and all payload bytes (mode 1).
  function automatic logic [FW-1:0] mk(input logic [7:0] cmd, input logic [PW-1:0] pl, input int mode);
    logic [7:0] b [18];
    logic [FW-1:0] f;
    b[0] = cmd;
    for (int i = 1; i <= 16; i++) b[i] = pl[8*(i-1) +: 8];
    b[17] = cmd;
    if (mode == 1) begin
      for (int i = 1; i <= 16; i++) b[17] = b[17] ^ b[i];
    end
    for (int i = 0; i < 18; i++) f[8*i +: 8] = b[i];
    return f;
  endfunction

  function automatic logic [PW-1:0] str_pl(input string s);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // ---------------- driver ----------------
  // Starts just after a rising edge with the DUT in IDLE; cycle 1 is the
  // cycle after the accepting edge. Ends just after a rising edge in IDLE.
  task automatic do_txn(input int sel, input string nm, input logic [FW-1:0] f,
                        input int dly, input logic [PW-1:0] val, input int busy,
                        input bit has, input logic [FW-1:0] ef, input int ecyc,
                        input bit eld, input int eerr);
    int send_n, ld_n, ld_c, send_c;
    bit fin;
    send_n = 0; ld_n = 0; ld_c = -1; send_c = -1; fin = 1'b0;
    if (has) exp_q.push_back(ef);
    rx_frame_a[sel] = f;
    rx_valid_a[sel] = 1'b1;
    tx_busy_a[sel]  = 1'b0;
    @(negedge clk);
    chk_i({nm, " rx_ready"}, int'(rx_ready_a[sel]), 1);
    @(posedge clk); #1;
    rx_valid_a[sel] = 1'b0;
    for (int c = 1; c <= 80 && !fin; c++) begin
      cop_done_a[sel]   = (dly >= 0) && (c == dly + 2);
      cop_result_a[sel] = cop_done_a[sel] ? val : ~val;
      tx_busy_a[sel]    = (c <= busy);
      @(negedge clk);
      if (cop_ld_a[sel]) begin ld_n++; ld_c = c; end
      if (tx_send_a[sel]) begin
        send_n++;
        send_c = c;
        if (exp_q.size() > 0) chk_v({nm, " tx_frame"}, tx_frame_a[sel], exp_q.pop_front());
      end
      if (c >= 2 && state_o_a[sel] == 2'd0) fin = 1'b1;
      @(posedge clk); #1;
    end
    cop_done_a[sel] = 1'b0;
    tx_busy_a[sel]  = 1'b0;
    exp_q.delete();
    chk_i({nm, " back to idle"}, int'(fin), 1);
    chk_i({nm, " tx_send count"}, send_n, int'(has));
    if (has) begin
      chk_i({nm, " tx_send cycle"}, send_c, ecyc);
      chk_v({nm, " tx_frame held"}, tx_frame_a[sel], ef);
    end
    chk_i({nm, " cop_ld count"}, ld_n, int'(eld));
    if (eld) chk_i({nm, " cop_ld cycle"}, ld_c, 1);
    chk_i({nm, " err_count"}, int'(err_count_a[sel]), eerr);
  endtask

  // ---------------- reference model (instance 0, CHECK_MODE=0) ----------------
  logic [PW-1:0] m_regs [4];
  logic [PW-1:0] m_res;
  int            m_err;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_res = '0;
    m_err = 0;
  endtask

  task automatic model(input logic [FW-1:0] f, input int dly, input logic [PW-1:0] val,
                       input int busy, output bit has, output logic [FW-1:0] ef,
                       output int ecyc, output bit eld);
    logic [7:0] hdr;
    logic [7:0] trl;
    logic [PW-1:0] pl;
    int start;
    bit nak;
    hdr = f[7:0];
    trl = f[FW-1 -: 8];
    pl  = f[FW-9:8];
    has = 1'b1; eld = 1'b0; nak = 1'b0; start = 2; ef = '0;
    if (trl != hdr) nak = 1'b1;
    else if (hdr == C_A) ef = mk(C_A, pl, 0);
    else if (hdr == C_B) ef = mk(C_B, m_res, 0);
    else if (hdr == C_E) begin
      eld = 1'b1;
      if (dly >= 0 && dly <= TO - 1) begin
        m_res = val;
        ef    = mk(C_E, val, 0);
        start = dly + 3;
      end else begin
        ef    = mk(C_T, '0, 0);
        start = TO + 2;
        if (m_err < 255) m_err++;
      end
    end
    else if (hdr >= 8'h30 && hdr <= 8'h33) begin
      m_regs[int'(hdr - 8'h30)] = pl;
      has = 1'b0;
    end
    else if (hdr >= 8'h61 && hdr <= 8'h64) ef = mk(hdr, m_regs[int'(hdr - 8'h61)], 0);
    else nak = 1'b1;
    if (nak) begin
      ef = mk(C_N, PW'(hdr), 0);
      if (m_err < 255) m_err++;
    end
    ecyc = (start > busy + 1) ? start : busy + 1;
  endtask

  task automatic rand_txn(input int idx);
    logic [7:0] cmd_tab [14];
    logic [7:0] cmd, trl;
    logic [PW-1:0] pl, val;
    logic [FW-1:0] f, ef;
    int dly, busy, ecyc;
    bit has, eld;
    cmd_tab = '{8'h41, 8'h42, 8'h45, 8'h30, 8'h31, 8'h32, 8'h33,
                8'h61, 8'h62, 8'h63, 8'h64, 8'h34, 8'h65, 8'h5A};
    cmd  = cmd_tab[$urandom_range(0, 13)];
    pl   = {$urandom, $urandom, $urandom, $urandom};
    val  = {$urandom, $urandom, $urandom, $urandom};
    trl  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : cmd;
    f    = {trl, pl, cmd};
    dly  = (cmd == C_E) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
    busy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : 0;
    model(f, dly, val, busy, has, ef, ecyc, eld);
    do_txn(0, $sformatf("rand%0d", idx), f, dly, val, busy, has, ef, ecyc, eld, m_err);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string         nm;
    logic [FW-1:0] f;
    int            dly;
    int            busy;
    logic [PW-1:0] val;
    bit            has;
    logic [7:0]    cmd;
    logic [PW-1:0] pl;
    int            cyc;
    bit            ld;
    int            err;
  } vec_t;

  vec_t tab [17];

  logic [PW-1:0] p_echo, p_inc, p2, aes, v2, v3;

  initial begin
    int acc, snd, ld_n;
    logic [FW-1:0] f, flip;
    bit has, eld;
    int ecyc;
    logic [FW-1:0] ef;

    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rx_valid_a[s] = 1'b0; rx_frame_a[s] = '0; tx_busy_a[s] = 1'b0;
      cop_done_a[s] = 1'b0; cop_result_a[s] = '0;
    end
    p_echo = str_pl("123456789012345A");
    p_inc  = 128'h0F0E0D0C0B0A09080706050403020100;
    p2     = 128'hDEADBEEF0123456789ABCDEF55AA33CC;
    aes    = 128'h3925841d02dc09fbdc118597196a0b32;
    v2     = 128'hCAFEF00D11223344556677889900AABB;
    v3     = 128'h0BADC0DEFEEDFACE1357924680A0B0C0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_i("reset state_o", int'(state_o_a[0]), 0);
    chk_i("reset rx_ready", int'(rx_ready_a[0]), 1);
    chk_i("reset tx_send", int'(tx_send_a[0]), 0);
    chk_i("reset cop_ld", int'(cop_ld_a[0]), 0);
    chk_i("reset err_count", int'(err_count_a[0]), 0);
    chk_v("reset tx_frame", tx_frame_a[0], '0);
    chk_v("reset cop_key", FW'(cop_key_a[0]), '0);
    chk_i("reset state_o dut1", int'(state_o_a[1]), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset taken while in RUN
    do_txn(0, "pre wr0", mk(8'h30, p2, 0), -1, '0, 0, 1'b0, '0, 0, 1'b0, 0);
    do_txn(0, "pre bad", {8'h5A, p2, C_A}, -1, '0, 0, 1'b1, mk(C_N, 128'h41, 0), 2, 1'b0, 1);
    rx_frame_a[0] = mk(C_E, '0, 0);
    rx_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    rx_valid_a[0] = 1'b0;
    @(negedge clk);
    chk_i("rst cop_ld in decode", int'(cop_ld_a[0]), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_i("rst in RUN", int'(state_o_a[0]), 2);
    rst = 1'b0;
    #1;
    chk_i("rst state_o", int'(state_o_a[0]), 0);
    chk_i("rst rx_ready", int'(rx_ready_a[0]), 1);
    chk_i("rst err_count", int'(err_count_a[0]), 0);
    chk_v("rst tx_frame", tx_frame_a[0], '0);
    chk_v("rst cop_key", FW'(cop_key_a[0]), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    ld_n = 0; snd = 0;
    for (int c = 0; c < 25; c++) begin
      cop_done_a[0]   = (c == 3);
      cop_result_a[0] = aes;
      @(negedge clk);
      if (cop_ld_a[0]) ld_n++;
      if (tx_send_a[0]) snd++;
      @(posedge clk); #1;
    end
    cop_done_a[0] = 1'b0;
    chk_i("post-rst cop_ld pulses", ld_n, 0);
    chk_i("post-rst tx_send pulses", snd, 0);
    chk_i("post-rst state_o", int'(state_o_a[0]), 0);

    // Directed vectors (instance 0)
    tab[0]  = '{"echo",      mk(C_A, p_echo, 0), -1,  0, '0,  1'b1, C_A,   p_echo,     2,  1'b0, 0};
    tab[1]  = '{"wr0",       mk(8'h30, p_inc, 0), -1, 0, '0,  1'b0, 8'h00, '0,         0,  1'b0, 0};
    tab[2]  = '{"rd a",      mk(8'h61, p2, 0),   -1,  0, '0,  1'b1, 8'h61, p_inc,      2,  1'b0, 0};
    tab[3]  = '{"wr1",       mk(8'h31, p2, 0),   -1,  0, '0,  1'b0, 8'h00, '0,         0,  1'b0, 0};
    tab[4]  = '{"rd b",      mk(8'h62, '0, 0),   -1,  0, '0,  1'b1, 8'h62, p2,         2,  1'b0, 0};
    tab[5]  = '{"bad trl",   {8'h5A, p_echo, C_A}, -1, 0, '0, 1'b1, C_N,   128'h41,    2,  1'b0, 1};
    tab[6]  = '{"unk 4",     mk(8'h34, p2, 0),   -1,  0, '0,  1'b1, C_N,   128'h34,    2,  1'b0, 2};
    tab[7]  = '{"unk e",     mk(8'h65, p2, 0),   -1,  0, '0,  1'b1, C_N,   128'h65,    2,  1'b0, 3};
    tab[8]  = '{"enc done",  mk(C_E, p2, 0),      4,  0, aes, 1'b1, C_E,   aes,        7,  1'b1, 3};
    tab[9]  = '{"read res",  mk(C_B, '0, 0),     -1,  0, '0,  1'b1, C_B,   aes,        2,  1'b0, 3};
    tab[10] = '{"timeout",   mk(C_E, '0, 0),     -1,  0, '0,  1'b1, C_T,   '0,         18, 1'b1, 4};
    tab[11] = '{"done last", mk(C_E, '0, 0),     15,  0, v2,  1'b1, C_E,   v2,         18, 1'b1, 4};
    tab[12] = '{"done late", mk(C_E, '0, 0),     16,  0, v3,  1'b1, C_T,   '0,         18, 1'b1, 5};
    tab[13] = '{"res kept",  mk(C_B, '0, 0),     -1,  0, '0,  1'b1, C_B,   v2,         2,  1'b0, 5};
    tab[14] = '{"echo busy", mk(C_A, p_echo, 0), -1, 10, '0,  1'b1, C_A,   p_echo,     11, 1'b0, 5};
    tab[15] = '{"tout busy", mk(C_E, '0, 0),     -1, 20, '0,  1'b1, C_T,   '0,         21, 1'b1, 6};
    tab[16] = '{"unk Z",     mk(8'h5A, p2, 0),   -1,  0, '0,  1'b1, C_N,   128'h5A,    2,  1'b0, 7};
    for (int i = 0; i < 17; i++) begin
      do_txn(0, tab[i].nm, tab[i].f, tab[i].dly, tab[i].val, tab[i].busy, tab[i].has,
             mk(tab[i].cmd, tab[i].pl, 0), tab[i].cyc, tab[i].ld, tab[i].err);
    end
    chk_v("cop_key after wr0", FW'(cop_key_a[0]), FW'(p_inc));
    chk_v("cop_text after wr1", FW'(cop_text_a[0]), FW'(p2));

    // rx_valid held high: one accept per IDLE visit
    rx_frame_a[0] = mk(C_A, p_echo, 0);
    rx_valid_a[0] = 1'b1;
    acc = 0; snd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rx_valid_a[0] && rx_ready_a[0]) acc++;
      if (tx_send_a[0]) begin
        snd++;
        chk_v("held valid tx_frame", tx_frame_a[0], mk(C_A, p_echo, 0));
      end
      @(posedge clk); #1;
    end
    rx_valid_a[0] = 1'b0;
    chk_i("held valid accepts", acc, 4);
    chk_i("held valid sends", snd, 4);
    chk_i("held valid err_count", int'(err_count_a[0]), 7);
    @(posedge clk); #1;

    // CHECK_MODE=1 (instance 1)
    do_txn(1, "m1 echo", mk(C_A, p_echo, 1), -1, '0, 0, 1'b1, mk(C_A, p_echo, 1), 2, 1'b0, 0);
    flip = 144'h1 << 20;
    f    = mk(C_A, p_echo, 1) ^ flip;
    do_txn(1, "m1 flip", f, -1, '0, 0, 1'b1, mk(C_N, 128'h41, 1), 2, 1'b0, 1);
    do_txn(1, "m1 wr2", mk(8'h32, p2, 1), -1, '0, 0, 1'b0, '0, 0, 1'b0, 1);
    do_txn(1, "m1 rd c", mk(8'h63, '0, 1), -1, '0, 0, 1'b1, mk(8'h63, p2, 1), 2, 1'b0, 1);
    do_txn(1, "m1 hdr trl", {C_A, 128'h1, C_A}, -1, '0, 0, 1'b1, mk(C_N, 128'h41, 1), 2, 1'b0, 2);

    // Randomized against the reference model, from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 120; i++) rand_txn(i);
    for (int i = 0; i < 300; i++) begin
      f = {8'h5A, {$urandom, $urandom, $urandom, $urandom}, C_A};
      model(f, -1, '0, 0, has, ef, ecyc, eld);
      do_txn(0, $sformatf("sat%0d", i), f, -1, '0, 0, has, ef, ecyc, eld, m_err);
    end
    chk_i("err_count saturated", int'(err_count_a[0]), 255);
    for (int i = 120; i < 150; i++) rand_txn(i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
